// File: rtl/trace_sequencer_if.sv
// trace_sequencer_if
//   Bundles the two buses the trace sequencer sits between:
//     - trace store lookup: InstructionNumber out, BranchAddress/BranchResult
//       back with one clock of read latency.
//     - predictor port: PredValid/PredAddress request with PredReady accept,
//       PredRespValid/Prediction response, and the one-cycle Update* strobe.
//   Handshake: a request transfers on a rising edge where PredValid and
//   PredReady are both 1; once PredValid rises it stays high with PredAddress
//   unchanged until that edge. PredRespValid is a single-cycle qualifier for
//   Prediction. UpdateValid qualifies the Update* fields for exactly one cycle.
//   Modports: master = trace_sequencer, slave = store/predictor side.
interface trace_sequencer_if #(
  parameter int ADDRESS_SIZE           = 8,
  parameter int INSTRUCTION_INDEX_SIZE = 22
);
  logic [INSTRUCTION_INDEX_SIZE-1:0] InstructionNumber;
  logic [ADDRESS_SIZE-1:0]           BranchAddress;
  logic                              BranchResult;
  logic                              PredValid;
  logic [ADDRESS_SIZE-1:0]           PredAddress;
  logic                              PredReady;
  logic                              PredRespValid;
  logic                              Prediction;
  logic                              UpdateValid;
  logic [ADDRESS_SIZE-1:0]           UpdateAddress;
  logic                              UpdateTaken;
  logic                              UpdateMispredict;

  modport master (
    output InstructionNumber, PredValid, PredAddress,
           UpdateValid, UpdateAddress, UpdateTaken, UpdateMispredict,
    input  BranchAddress, BranchResult, PredReady, PredRespValid, Prediction
  );

  modport slave (
    input  InstructionNumber, PredValid, PredAddress,
           UpdateValid, UpdateAddress, UpdateTaken, UpdateMispredict,
    output BranchAddress, BranchResult, PredReady, PredRespValid, Prediction
  );
endinterface

// File: rtl/trace_sequencer.sv
// trace_sequencer
//   Trace-driven initiator for branch-predictor evaluation. Walks trace index
//   0 .. TRAINING_DATA_SIZE-1; for each entry it reads the store, issues a
//   prediction request, waits for the response, then emits a one-cycle update
//   carrying the true outcome. Branch and mispredict counts saturate.
//
// Ports
//   Clk, reset        : rising-edge clock, synchronous active-high reset
//   Start             : single-cycle run request (honoured in IDLE/DONE only)
//   bus (master)      : trace store lookup + predictor request/update bus
//   Busy              : run in progress (FETCH..UPD)
//   Done              : run complete, held until Start or reset
//   Error             : watchdog abort flag (0 when watchdog not built)
//   BranchCount       : branches completed in this run
//   MispredictCount   : mispredicted branches in this run
//   dbg_state         : current FSM state encoding
//
// Optional feature
//   TRACE_SEQ_WATCHDOG_EN : adds an 8-bit stall watchdog on REQ/RESP that
//   aborts the run to DONE with Error=1.
module trace_sequencer #(
  parameter int ADDRESS_SIZE           = 8,
  parameter int TRAINING_DATA_SIZE     = 3898078,
  parameter int INSTRUCTION_INDEX_SIZE = $clog2(TRAINING_DATA_SIZE),
  parameter int COUNT_WIDTH            = 32
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   Start,
  trace_sequencer_if.master      bus,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Error,
  output logic [COUNT_WIDTH-1:0] BranchCount,
  output logic [COUNT_WIDTH-1:0] MispredictCount,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_REQ   = 3'd3,
    S_RESP  = 3'd4,
    S_UPD   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [INSTRUCTION_INDEX_SIZE-1:0] LAST_IDX =
    INSTRUCTION_INDEX_SIZE'(TRAINING_DATA_SIZE - 1);

  state_t                            state_q, state_d;
  logic [INSTRUCTION_INDEX_SIZE-1:0] idx_q, idx_d;
  logic [ADDRESS_SIZE-1:0]           addr_q, addr_d;
  logic                              taken_q, taken_d;
  logic                              pred_q, pred_d;
  logic [COUNT_WIDTH-1:0]            bcnt_q, bcnt_d;
  logic [COUNT_WIDTH-1:0]            mcnt_q, mcnt_d;

  logic pred_valid;
  logic upd_valid;
  logic mispredict;
  logic start_run;

`ifdef TRACE_SEQ_WATCHDOG_EN
  // The counter starts at 0 on entry, so aborting when it already holds 254
  // gives exactly 255 stalled cycles in the state before the abort.
  localparam logic [7:0] WD_LAST = 8'd254;
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
`endif

  assign start_run  = Start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign mispredict = pred_q ^ taken_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    taken_d    = taken_q;
    pred_d     = pred_q;
    bcnt_d     = bcnt_q;
    mcnt_d     = mcnt_q;
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
`ifdef TRACE_SEQ_WATCHDOG_EN
    wd_d       = wd_q;
    err_d      = err_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) state_d = S_FETCH;
      end
      // Index is already stable; the store registers its data at this edge.
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        addr_d  = bus.BranchAddress;
        taken_d = bus.BranchResult;
        state_d = S_REQ;
`ifdef TRACE_SEQ_WATCHDOG_EN
        wd_d    = 8'd0;
`endif
      end
      S_REQ: begin
        pred_valid = 1'b1;
        if (bus.PredReady) begin
          state_d = S_RESP;
`ifdef TRACE_SEQ_WATCHDOG_EN
          wd_d    = 8'd0;
`endif
        end else begin
`ifdef TRACE_SEQ_WATCHDOG_EN
          if (wd_q == WD_LAST) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + 8'd1;
          end
`endif
        end
      end
      // Responses are only meaningful here; PredRespValid elsewhere is ignored.
      S_RESP: begin
        if (bus.PredRespValid) begin
          pred_d  = bus.Prediction;
          state_d = S_UPD;
        end else begin
`ifdef TRACE_SEQ_WATCHDOG_EN
          if (wd_q == WD_LAST) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + 8'd1;
          end
`endif
        end
      end
      S_UPD: begin
        upd_valid = 1'b1;
        if (bcnt_q != {COUNT_WIDTH{1'b1}}) bcnt_d = bcnt_q + 1'b1;
        if (mispredict && (mcnt_q != {COUNT_WIDTH{1'b1}})) mcnt_d = mcnt_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new run always starts from index 0 with clean statistics.
    if (start_run) begin
      idx_d  = '0;
      bcnt_d = '0;
      mcnt_d = '0;
`ifdef TRACE_SEQ_WATCHDOG_EN
      err_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      taken_q <= 1'b0;
      pred_q  <= 1'b0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
`ifdef TRACE_SEQ_WATCHDOG_EN
      wd_q    <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      taken_q <= taken_d;
      pred_q  <= pred_d;
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
`ifdef TRACE_SEQ_WATCHDOG_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  // Data outputs are gated by their qualifiers so idle/reset reads as all-zero.
  assign bus.InstructionNumber = idx_q;
  assign bus.PredValid         = pred_valid;
  assign bus.PredAddress       = pred_valid ? addr_q : '0;
  assign bus.UpdateValid       = upd_valid;
  assign bus.UpdateAddress     = upd_valid ? addr_q : '0;
  assign bus.UpdateTaken       = upd_valid & taken_q;
  assign bus.UpdateMispredict  = upd_valid & mispredict;

  assign Busy            = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                           (state_q == S_REQ)   || (state_q == S_RESP) ||
                           (state_q == S_UPD);
  assign Done            = (state_q == S_DONE);
  assign BranchCount     = bcnt_q;
  assign MispredictCount = mcnt_q;
  assign dbg_state       = state_q;

`ifdef TRACE_SEQ_WATCHDOG_EN
  assign Error = err_q;
`else
  assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_trace_sequencer.sv
module tb_trace_sequencer;
  localparam int AW  = 8;
  localparam int TDS = 4;
  localparam int IW  = 2;
  localparam int CW  = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd6;

  // ---------------- clock / reset ----------------
  logic Clk   = 1'b0;
  logic reset = 1'b1;
  logic Start = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic          Busy, Done, Error;
  logic [CW-1:0] BranchCount, MispredictCount;
  logic [2:0]    dbg_state;

  trace_sequencer_if #(.ADDRESS_SIZE(AW), .INSTRUCTION_INDEX_SIZE(IW)) bus ();

  trace_sequencer #(
    .ADDRESS_SIZE(AW), .TRAINING_DATA_SIZE(TDS),
    .INSTRUCTION_INDEX_SIZE(IW), .COUNT_WIDTH(CW)
  ) dut (
    .Clk(Clk), .reset(reset), .Start(Start), .bus(bus),
    .Busy(Busy), .Done(Done), .Error(Error),
    .BranchCount(BranchCount), .MispredictCount(MispredictCount),
    .dbg_state(dbg_state)
  );

  // ---------------- store + predictor models ----------------
  logic [AW-1:0] tbl_addr [TDS];
  logic          tbl_taken[TDS];
  logic          pred_ready = 1'b0, auto_resp = 1'b0, pred_value = 1'b1;
  logic          spur_resp = 1'b0, spur_pred = 1'b0;
  logic          acc_seen = 1'b0, resp_pend = 1'b0;
  logic [IW-1:0] store_idx = '0;
  logic [AW-1:0] store_addr = '0;
  logic          store_taken = 1'b0;

  // Sample on the falling edge, register on the rising edge (no races).
  always @(negedge Clk) begin
    acc_seen  = bus.PredValid & bus.PredReady;
    store_idx = bus.InstructionNumber;
  end
  always @(posedge Clk) begin
    resp_pend   <= acc_seen;
    store_addr  <= tbl_addr[store_idx];
    store_taken <= tbl_taken[store_idx];
  end

  assign bus.BranchAddress = store_addr;
  assign bus.BranchResult  = store_taken;
  assign bus.PredReady     = pred_ready;
  assign bus.PredRespValid = (auto_resp & resp_pend) | spur_resp;
  assign bus.Prediction    = (auto_resp & resp_pend) ? pred_value : spur_pred;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [AW+1:0] exp_q[$];  // {addr, taken, mispredict}
  logic [AW+1:0] exp_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int upd_cnt, acc_cnt, resp_cycles, exp_bcnt, exp_mcnt;
  int fetch_cyc, pv_cyc, last_upd_cyc, done_cyc;
  logic prev_upd;

  task automatic clear_mon();
    upd_cnt = 0; acc_cnt = 0; resp_cycles = 0; exp_bcnt = 0; exp_mcnt = 0;
    fetch_cyc = -1; pv_cyc = -1; last_upd_cyc = -1; done_cyc = -1;
    prev_upd = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (prev_upd) begin
      check("bcnt_after_upd", BranchCount, exp_bcnt);
      check("mcnt_after_upd", MispredictCount, exp_mcnt);
    end
    if (bus.UpdateValid) begin
      upd_cnt++;
      last_upd_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("upd_unexpected", 1, 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("upd_fields", {bus.UpdateAddress, bus.UpdateTaken, bus.UpdateMispredict}, exp_e);
        exp_bcnt++;
        if (exp_e[0]) exp_mcnt++;
      end
    end
    prev_upd = bus.UpdateValid;
    if (bus.PredValid && bus.PredReady) acc_cnt++;
    if (dbg_state == ST_RESP) resp_cycles++;
    if (dbg_state == ST_FETCH && fetch_cyc < 0) fetch_cyc = cyc;
    if (bus.PredValid && pv_cyc < 0) pv_cyc = cyc;
    if (Done && done_cyc < 0) done_cyc = cyc;
  end

  // ---------------- driver tasks ----------------
  // Predictor always answers taken: mispredict = !outcome (hand values).
  task automatic push_run_exp();
    exp_q.push_back({8'hA0, 1'b1, 1'b0});
    exp_q.push_back({8'h5B, 1'b0, 1'b1});
    exp_q.push_back({8'hC3, 1'b1, 1'b0});
    exp_q.push_back({8'h17, 1'b1, 1'b0});
  endtask

  int start_cyc;
  task automatic start_pulse();
    @(posedge Clk); #1;
    Start = 1'b1;
    start_cyc = cyc;
    @(posedge Clk); #1;
    Start = 1'b0;
    clear_mon();
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (!Done && n < max_cyc) begin
      @(negedge Clk);
      n++;
    end
    check("done_timeout", Done, 1);
    @(posedge Clk); #1;
  endtask

  task automatic check_idle_outputs();
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_index", bus.InstructionNumber, 0);
    check("rst_pvalid", bus.PredValid, 0);
    check("rst_paddr", bus.PredAddress, 0);
    check("rst_uvalid", bus.UpdateValid, 0);
    check("rst_uaddr", bus.UpdateAddress, 0);
    check("rst_utaken", bus.UpdateTaken, 0);
    check("rst_umis", bus.UpdateMispredict, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_error", Error, 0);
    check("rst_bcnt", BranchCount, 0);
    check("rst_mcnt", MispredictCount, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  // ---------------- directed tests ----------------
  initial begin
    int n;
    tbl_addr[0] = 8'hA0; tbl_taken[0] = 1'b1;
    tbl_addr[1] = 8'h5B; tbl_taken[1] = 1'b0;
    tbl_addr[2] = 8'hC3; tbl_taken[2] = 1'b1;
    tbl_addr[3] = 8'h17; tbl_taken[3] = 1'b1;
    clear_mon();

    repeat (3) @(posedge Clk);
    #1;
    check_idle_outputs();
    reset = 1'b0;

    // T1: full run, zero-stall predictor answering taken.
    pred_ready = 1'b1; auto_resp = 1'b1; pred_value = 1'b1;
    push_run_exp();
    start_pulse();
    check("t1_fetch_state", dbg_state, ST_FETCH);
    check("t1_busy", Busy, 1);
    wait_done(60);
    check("t1_fetch_latency", fetch_cyc - start_cyc, 1);
    check("t1_pv_latency", pv_cyc - start_cyc, 3);
    check("t1_fetch_to_last_upd", last_upd_cyc - fetch_cyc + 1, 20);
    check("t1_done_after_upd", done_cyc - last_upd_cyc, 1);
    check("t1_upd_cnt", upd_cnt, 4);
    check("t1_bcnt", BranchCount, 4);
    check("t1_mcnt", MispredictCount, 1);
    check("t1_busy_done", Busy, 0);
    check("t1_index_last", bus.InstructionNumber, 3);
    check("t1_exp_empty", exp_q.size(), 0);

    // T2: restart from DONE, REQ stall with spurious responses, Start while busy.
    pred_ready = 1'b0; spur_resp = 1'b1; spur_pred = 1'b0;
    push_run_exp();
    start_pulse();
    check("t2_done_cleared", Done, 0);
    check("t2_bcnt_cleared", BranchCount, 0);
    check("t2_mcnt_cleared", MispredictCount, 0);
    n = 0;
    while (!bus.PredValid && n < 10) begin
      @(negedge Clk);
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      check("t2_pv_hold", bus.PredValid, 1);
      check("t2_pa_hold", bus.PredAddress, 8'hA0);
      @(posedge Clk); #1;
      if (i == 1) Start = 1'b1;
      if (i == 2) Start = 1'b0;
      if (i == 5) begin
        pred_ready = 1'b1;
        spur_resp  = 1'b0;
      end
      if (i < 5) @(negedge Clk);
    end
    check("t2_still_req", dbg_state, ST_REQ);
    check("t2_index_hold", bus.InstructionNumber, 0);
    wait_done(80);
    check("t2_acc_cnt", acc_cnt, 4);
    check("t2_upd_cnt", upd_cnt, 4);
    check("t2_bcnt", BranchCount, 4);
    check("t2_mcnt", MispredictCount, 1);
    check("t2_exp_empty", exp_q.size(), 0);

    // T3: reset during RESP of index 2, then a clean re-run.
    push_run_exp();
    start_pulse();
    n = 0;
    while (!(dbg_state == ST_RESP && bus.InstructionNumber == 2) && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("t3_reached_resp2", {dbg_state, bus.InstructionNumber}, {ST_RESP, 2'd2});
    reset = 1'b1;
    @(posedge Clk); #1;
    check_idle_outputs();
    @(posedge Clk); #1;
    check("t3_upd_before_rst", upd_cnt, 2);
    check("t3_exp_left", exp_q.size(), 2);
    reset = 1'b0;
    exp_q.delete();
    push_run_exp();
    start_pulse();
    check("t3_rerun_index", bus.InstructionNumber, 0);
    check("t3_rerun_bcnt", BranchCount, 0);
    wait_done(60);
    check("t3_upd_cnt", upd_cnt, 4);
    check("t3_bcnt", BranchCount, 4);
    check("t3_mcnt", MispredictCount, 1);

    // T4: predictor accepts but never responds.
    auto_resp = 1'b0; pred_ready = 1'b1;
    start_pulse();
`ifdef TRACE_SEQ_WATCHDOG_EN
    wait_done(600);
    check("t4_error", Error, 1);
    check("t4_resp_cycles", resp_cycles, 255);
    check("t4_upd_cnt", upd_cnt, 0);
    check("t4_bcnt", BranchCount, 0);
    check("t4_pv_dropped", bus.PredValid, 0);
    start_pulse();
    check("t4_error_cleared", Error, 0);
    check("t4_done_cleared", Done, 0);
`else
    repeat (300) @(negedge Clk);
    check("t4_stuck_resp", dbg_state, ST_RESP);
    check("t4_error", Error, 0);
    check("t4_busy", Busy, 1);
    check("t4_upd_cnt", upd_cnt, 0);
`endif
    @(posedge Clk); #1;
    reset = 1'b1;
    @(posedge Clk); #1;
    check("t4_reset_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    repeat (2) @(posedge Clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
